// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-organised off-chip data memory model.
// The optional access counters are enabled with the DMEM_ACCESS_COUNT_EN macro.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Smallest w with 2**w >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, combinational read.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINE_W = dmem_pkg::LINE_W,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the contents are preloaded externally and
  // clearing a large array would only turn it into a wide register file.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency line memory answering cache refill/write-back requests.
// Define DMEM_ACCESS_COUNT_EN to add read/write access counters.
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              busy_o
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  localparam int IDX_W = clog2(DEPTH);
  // Counter holds at most LATENCY-2.
  localparam int CNT_W = (LATENCY > 2) ? clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_write_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [LINE_W-1:0] req_data_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] arr_rdata;
  logic              accept;
  logic              enter_ack;
  logic              unused_addr_bits;

  // Offset bits select bytes within a line; upper bits alias modulo DEPTH.
  assign unused_addr_bits = ^{mem_addr_i[ADDR_W-1:OFFSET_W+IDX_W],
                              mem_addr_i[OFFSET_W-1:0]};

  assign accept    = (state_q == IDLE) && mem_enable_i;
  assign enter_ack = (state_q == WAIT) && (cnt_q == '0);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_enable_i) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_write_q <= mem_write_i;
        req_idx_q   <= mem_addr_i[OFFSET_W +: IDX_W];
        req_data_q  <= mem_data_i;
      end
      if (enter_ack && !req_write_q) rdata_q <= arr_rdata;
    end
  end

  // Write commits on the edge leaving ACK, before any new acceptance.
  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    ((state_q == ACK) && req_write_q),
    .idx_i   (req_idx_q),
    .wdata_i (req_data_q),
    .rdata_o (arr_rdata)
  );

  assign mem_ack_o  = (state_q == ACK);
  assign mem_data_o = rdata_q;
  assign busy_o     = (state_q != IDLE);

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q, wr_count_q;

  // Counts become visible in the ACK cycle of the access they record.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (enter_ack) begin
      if (req_write_q) wr_count_q <= wr_count_q + 32'd1;
      else             rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed plus randomized bench for dmem_line_ctrl against a line-level model.
module tb_dmem_line_ctrl;

  localparam int LW    = 256;
  localparam int AW    = 32;
  localparam int DEPTH = 512;
  localparam int LAT   = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          mem_enable_i = 1'b0;
  logic          mem_write_i  = 1'b0;
  logic [AW-1:0] mem_addr_i   = '0;
  logic [LW-1:0] mem_data_i   = '0;
  logic          mem_ack_o;
  logic [LW-1:0] mem_data_o;
  logic          busy_o;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0]   rd_count_o, wr_count_o;
  int            exp_rd = 0;
  int            exp_wr = 0;
`endif

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [LW-1:0] model_mem [int];
  logic [LW-1:0] model_dout = '0;

  dmem_line_ctrl #(
    .LINE_W  (LW),
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_enable_i (mem_enable_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_ack_o    (mem_ack_o),
    .mem_data_o   (mem_data_o),
    .busy_o       (busy_o)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count_o   (rd_count_o),
    .wr_count_o   (wr_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [AW-1:0] addr);
    return int'((addr >> 5) % DEPTH);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int j = 0; j < LW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  // Entered at a falling edge with the DUT idle; that cycle is cycle 0.
  // Returns at the falling edge of the first idle cycle after the ack.
  task automatic run_req(input logic w, input logic [AW-1:0] addr,
                         input logic [LW-1:0] data, input bit scramble);
    int idx;
    idx = line_of(addr);
    check_bit("idle_before_req", busy_o, 1'b0);
    mem_enable_i = 1'b1;
    mem_write_i  = w;
    mem_addr_i   = addr;
    mem_data_i   = data;
    if (!w) model_dout = model_mem.exists(idx) ? model_mem[idx] : '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk_i);
      check_bit("busy_during_req", busy_o, 1'b1);
      check_bit("ack_timing", mem_ack_o, k == LAT);
      if (k == LAT) begin
        check_line("ack_data", mem_data_o, model_dout);
`ifdef DMEM_ACCESS_COUNT_EN
        if (w) exp_wr++;
        else   exp_rd++;
        check_line("rd_count", LW'(rd_count_o), LW'(exp_rd));
        check_line("wr_count", LW'(wr_count_o), LW'(exp_wr));
`endif
        mem_enable_i = 1'b0;
      end else if (scramble) begin
        mem_enable_i = 1'($urandom_range(0, 1));
        mem_write_i  = 1'($urandom_range(0, 1));
        mem_addr_i   = $urandom;
        mem_data_i   = rand_line();
      end else begin
        mem_enable_i = 1'b0;
      end
    end
    @(negedge clk_i);
    check_bit("ack_single_cycle", mem_ack_o, 1'b0);
    check_bit("idle_after_ack", busy_o, 1'b0);
    check_line("data_held", mem_data_o, model_dout);
    if (w) model_mem[idx] = data;
  endtask

  initial begin
    logic [LW-1:0] old_line2;
    logic [AW-1:0] addr;
    int            idx;

    // Reset held for three cycles, then a long idle stretch.
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check_bit("reset_ack", mem_ack_o, 1'b0);
      check_bit("reset_busy", busy_o, 1'b0);
      check_line("reset_data", mem_data_o, '0);
    end
    rst_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      check_bit("idle_ack", mem_ack_o, 1'b0);
      check_bit("idle_busy", busy_o, 1'b0);
      check_line("idle_data", mem_data_o, '0);
    end

    // Preload line 4 and line 2, then read line 4 at byte address 0x80.
    run_req(1'b1, 32'h0000_0080, {32{8'hA5}}, 1'b0);
    run_req(1'b1, 32'h0000_0040, 256'hC0FFEE_0000_BEEF, 1'b0);
    run_req(1'b0, 32'h0000_0080, '0, 1'b0);
    check_line("read_line4", mem_data_o, {32{8'hA5}});

    // Write then read the same line with different offset bits.
    run_req(1'b1, 32'h0000_0100, 256'h1234, 1'b0);
    run_req(1'b0, 32'h0000_011F, '0, 1'b0);
    check_line("offset_ignored", mem_data_o, 256'h1234);

    // Inputs wiggled throughout WAIT must not disturb the latched request.
    run_req(1'b1, 32'h0000_0300, 256'hDEAD_0000_BEEF_0001, 1'b1);
    run_req(1'b0, 32'h0000_0300, '0, 1'b1);
    check_line("latched_inputs", mem_data_o, 256'hDEAD_0000_BEEF_0001);

    // Reset asserted mid-write: no ack, no commit.
    old_line2 = model_mem[2];
    mem_enable_i = 1'b1;
    mem_write_i  = 1'b1;
    mem_addr_i   = 32'h0000_0040;
    mem_data_i   = 256'hFF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      mem_enable_i = 1'b0;
      if (k < 5) check_bit("pre_reset_ack", mem_ack_o, 1'b0);
    end
    rst_i = 1'b0;
    #1;
    check_bit("midreset_busy", busy_o, 1'b0);
    check_bit("midreset_ack", mem_ack_o, 1'b0);
    check_line("midreset_data", mem_data_o, '0);
    model_dout = '0;
`ifdef DMEM_ACCESS_COUNT_EN
    exp_rd = 0;
    exp_wr = 0;
    check_line("midreset_rd_count", LW'(rd_count_o), '0);
`endif
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk_i);
      check_bit("post_reset_no_ack", mem_ack_o, 1'b0);
      check_bit("post_reset_idle", busy_o, 1'b0);
    end
    run_req(1'b0, 32'h0000_0040, '0, 1'b0);
    check_line("line2_not_committed", mem_data_o, old_line2);

    // Upper address bits alias onto line 0.
    run_req(1'b1, 32'h0000_4000, 256'h5A5A_0BAD_F00D, 1'b0);
    run_req(1'b0, 32'h0000_0000, '0, 1'b0);
    check_line("alias_wrap", mem_data_o, 256'h5A5A_0BAD_F00D);

    // Randomized mix over a small pool of lines, all seeded first.
    for (int i = 16; i < 24; i++) begin
      run_req(1'b1, AW'(i) << 5, rand_line(), 1'b0);
    end
    for (int n = 0; n < 30; n++) begin
      idx  = 16 + int'($urandom_range(0, 7));
      addr = ($urandom & ~32'h0000_3FE0) | (AW'(idx) << 5);
      run_req(1'($urandom_range(0, 1)), addr, rand_line(), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_line_ctrl.md
Name: dmem_line_ctrl

Overview:
Off-chip data memory model behind the data cache. It consumes the cache's line-refill and write-back requests over the 256-bit mem_* interface and answers each one with a single-cycle ack after a fixed latency. It holds a line-organised storage array, a request register, a latency counter and a 3-state FSM. The CPU top instantiates it in the testbench next to the instruction memory.

Parameters:
- LINE_W, 256: line width in bits; must match the cache line.
- ADDR_W, 32: request address width.
- DEPTH, 512: number of lines; power of two.
- LATENCY, 10: cycles from request acceptance to ack; must be ≥2.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-low.
- mem_enable_i, in, 1: request valid.
- mem_write_i, in, 1: 1 = write line, 0 = read line.
- mem_addr_i, in, ADDR_W: byte address; bits [4:0] ignored.
- mem_data_i, in, LINE_W: write line data.
- mem_ack_o, out, 1: one-cycle completion pulse.
- mem_data_o, out, LINE_W: read line data, valid when mem_ack_o=1.
- busy_o, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0, mem_ack_o=0, mem_data_o=0, busy_o=0.
  - Request register is cleared.
  - Storage array is not cleared; the testbench preloads it.
- Line index: mem_addr_i[5+log2(DEPTH)-1:5]. Upper address bits alias (wrap modulo DEPTH).
- IDLE:
  - If mem_enable_i=1 at a rising edge, latch addr, write and data, load counter=LATENCY-2, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - While counter≠0, decrement it.
  - When counter=0, go to ACK.
  - Inputs are ignored; changes to addr or data mid-request have no effect.
- ACK (exactly one cycle):
  - mem_ack_o=1.
  - Read: mem_data_o is loaded from the array on the edge entering ACK, so it is valid in the ACK cycle.
  - Write: the array line is written on the edge leaving ACK; mem_data_o is unchanged.
  - Next state is always IDLE.
- Latency: if the request is accepted at edge E, the ack is high in the cycle after edge E+(LATENCY-1), i.e. LATENCY cycles after the request cycle.
- mem_data_o holds its last read value until the next read completes.
- Back-to-back requests:
  - The earliest new acceptance is the IDLE cycle after ACK.
  - If mem_enable_i is still high in that cycle, it is treated as a new request. The cache must drop enable on seeing ack.
- Read after write to the same line: the read returns the written data, because the write commits before any subsequent acceptance.
- Reset asserted mid-request: the request is discarded and no ack is issued. A pending write is not committed.
- mem_enable_i during WAIT or ACK is ignored; no queuing.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each increments in its ACK cycle (read or write respectively).
  - Both are cleared by reset and wrap at 2^32.
- When undefined: the ports and counters are absent. Core timing is identical either way.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, ACK}.
  - LINE_W and OFFSET_W=5 constants.
  - Index-width function clog2(DEPTH).
- Sub-module dmem_line_array:
  - DEPTH×LINE_W, single port.
  - Synchronous write (we, idx, wdata); combinational read (idx → rdata).
  - The FSM, counter and request register stay in dmem_line_ctrl.

Test Plan:
- Reset then idle: hold rst_i=0 for 3 cycles, release, run 20 cycles with enable=0 → ack=0, busy=0, mem_data_o=0 throughout.
- Read latency (LATENCY=10): preload line 4 = 256'hA5…A5; enable=1, write=0, addr=0x80 in cycle 0 → ack high only in cycle 10, mem_data_o=A5…A5, busy high in cycles 1–10.
- Write then read: write 256'h1234 to addr 0x100; after ack, read addr 0x11F → returns 256'h1234 (offset bits ignored).
- Input stability: change addr/data every cycle during WAIT → completed access uses the values latched in cycle 0; exactly one ack.
- Reset mid-write: write addr 0x40 with data 0xFF, assert rst_i in cycle 5 → no ack, line 2 keeps its old value, state IDLE.
- Wrap/alias plus counters (with DMEM_ACCESS_COUNT_EN): write addr 0x4000 (DEPTH=512), read addr 0x0 → same data; rd_count_o=1, wr_count_o=1.
